// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions for the device-side response integrity path:
// integrity widths, payload layout and the response-integrity packing helper.
package tlul_pkg;

   localparam int H2DCmdIntgWidth = 7;
   localparam int D2HRspIntgWidth = 7;
   localparam int DataIntgWidth   = 7;
   localparam int H2DCmdMaxWidth  = 57;
   localparam int D2HRspMaxWidth  = 57;
   localparam int DataMaxWidth    = 32;
   localparam int TlSzW           = 2;

   typedef struct packed {
      logic [2:0]       opcode;
      logic [TlSzW-1:0] size;
      logic             error;
   } tl_d2h_rsp_intg_t;

   // Encoding is {skid_valid, out_valid}; 2'b10 can never occur.
   typedef enum logic [1:0] {
      StEmpty = 2'b00,
      StOne   = 2'b01,
      StFull  = 2'b11
   } skid_state_e;

   function automatic logic [D2HRspMaxWidth-1:0] extract_d2h_rsp_intg(tl_d2h_rsp_intg_t rsp);
      return D2HRspMaxWidth'(rsp);
   endfunction

endpackage

// File: rtl/prim_secded_inv_39_32_enc.sv
// Inverted Hsiao (39,32) SECDED encoder: 32 data bits followed by 7 check bits,
// with the check bits XORed by 7'h2A.
module prim_secded_inv_39_32_enc (
   input  logic [31:0] data_i,
   output logic [38:0] data_o
);

   logic [38:0] w_ext;
   logic [6:0]  w_check;

   assign w_ext = 39'(data_i);

   assign w_check[0] = ^(w_ext & 39'h002606BD25);
   assign w_check[1] = ^(w_ext & 39'h00DEBA8050);
   assign w_check[2] = ^(w_ext & 39'h00413D89AA);
   assign w_check[3] = ^(w_ext & 39'h0031234ED1);
   assign w_check[4] = ^(w_ext & 39'h00C2C1323B);
   assign w_check[5] = ^(w_ext & 39'h002DCC624C);
   assign w_check[6] = ^(w_ext & 39'h0098505586);

   assign data_o = {w_check ^ 7'h2A, data_i};

endmodule

// File: rtl/prim_secded_inv_64_57_enc.sv
// Inverted Hsiao (64,57) SECDED encoder: 57 data bits followed by 7 check bits,
// with the check bits XORed by 7'h2A so that all-zero data is not a valid codeword.
module prim_secded_inv_64_57_enc (
   input  logic [56:0] data_i,
   output logic [63:0] data_o
);

   logic [63:0] w_ext;
   logic [6:0]  w_check;

   assign w_ext = 64'(data_i);

   assign w_check[0] = ^(w_ext & 64'h0103FFF800007FFF);
   assign w_check[1] = ^(w_ext & 64'h017C1FF801FF801F);
   assign w_check[2] = ^(w_ext & 64'h01BDE1F87E0781E1);
   assign w_check[3] = ^(w_ext & 64'h01DEEE3B8E388E22);
   assign w_check[4] = ^(w_ext & 64'h01EF76CDB2C93244);
   assign w_check[5] = ^(w_ext & 64'h01F7BB56D5525488);
   assign w_check[6] = ^(w_ext & 64'h01FBDDA769A46910);

   assign data_o = {w_check ^ 7'h2A, data_i};

endmodule

// File: rtl/tlul_rsp_intg_gen.sv
// Combinational generation of D-channel response-command and data integrity,
// with optional pass-through of upstream-supplied integrity.
module tlul_rsp_intg_gen
   import tlul_pkg::*;
#(
   parameter bit EnableRspIntgGen  = 1'b1,
   parameter bit EnableDataIntgGen = 1'b1,
   parameter int SzW               = 2
) (
   input  logic [2:0]                 d_opcode_i,
   input  logic [SzW-1:0]             d_size_i,
   input  logic                       d_error_i,
   input  logic [DataMaxWidth-1:0]    d_data_i,
   input  logic [D2HRspIntgWidth-1:0] rsp_intg_i,
   input  logic [DataIntgWidth-1:0]   data_intg_i,
   output logic [D2HRspIntgWidth-1:0] rsp_intg_o,
   output logic [DataIntgWidth-1:0]   data_intg_o
);

   logic [D2HRspMaxWidth-1:0] w_rspPayload;
   logic [63:0]               w_rspCode;
   logic [38:0]               w_dataCode;
   logic                      w_unused;

   // Packing is error at bit 0, then size, then opcode, zero-extended.
   if (SzW == TlSzW) begin : g_pkgPack
      tl_d2h_rsp_intg_t w_rspFields;
      assign w_rspFields  = '{opcode: d_opcode_i, size: d_size_i, error: d_error_i};
      assign w_rspPayload = extract_d2h_rsp_intg(w_rspFields);
   end else begin : g_genericPack
      assign w_rspPayload = D2HRspMaxWidth'({d_opcode_i, d_size_i, d_error_i});
   end

   prim_secded_inv_64_57_enc u_rspEnc (
      .data_i (w_rspPayload),
      .data_o (w_rspCode)
   );

   prim_secded_inv_39_32_enc u_dataEnc (
      .data_i (d_data_i),
      .data_o (w_dataCode)
   );

   assign rsp_intg_o  = EnableRspIntgGen  ? w_rspCode[63:57]  : rsp_intg_i;
   assign data_intg_o = EnableDataIntgGen ? w_dataCode[38:32] : data_intg_i;

   assign w_unused = ^{rsp_intg_i, data_intg_i, w_rspCode[56:0], w_dataCode[31:0]};

endmodule

// File: rtl/tlul_rsp_intg_gen_skid.sv
// Device-side TL-UL D-channel egress: adds integrity to a raw response and
// presents it through a 2-entry skid buffer whose ready is purely registered.
module tlul_rsp_intg_gen_skid
   import tlul_pkg::*;
#(
   parameter bit EnableRspIntgGen  = 1'b1,
   parameter bit EnableDataIntgGen = 1'b1,
   parameter int SzW               = 2,
   parameter int AiW               = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       d_valid_i,
   output logic                       d_ready_o,
   input  logic [2:0]                 d_opcode_i,
   input  logic [2:0]                 d_param_i,
   input  logic [SzW-1:0]             d_size_i,
   input  logic [AiW-1:0]             d_source_i,
   input  logic                       d_sink_i,
   input  logic [DataMaxWidth-1:0]    d_data_i,
   input  logic                       d_error_i,
   input  logic [D2HRspIntgWidth-1:0] rsp_intg_i,
   input  logic [DataIntgWidth-1:0]   data_intg_i,
   output logic                       d_valid_o,
   input  logic                       d_ready_i,
   output logic [2:0]                 d_opcode_o,
   output logic [2:0]                 d_param_o,
   output logic [SzW-1:0]             d_size_o,
   output logic [AiW-1:0]             d_source_o,
   output logic                       d_sink_o,
   output logic [DataMaxWidth-1:0]    d_data_o,
   output logic                       d_error_o,
   output logic [D2HRspIntgWidth-1:0] rsp_intg_o,
   output logic [DataIntgWidth-1:0]   data_intg_o
);

   localparam int PayloadW = 3 + 3 + SzW + AiW + 1 + DataMaxWidth + 1
                           + D2HRspIntgWidth + DataIntgWidth;

   logic [D2HRspIntgWidth-1:0] w_rspIntg;
   logic [DataIntgWidth-1:0]   w_dataIntg;
   logic [PayloadW-1:0]        w_inPayload;
   logic [PayloadW-1:0]        r_outPayload;
   logic [PayloadW-1:0]        r_skidPayload;
   skid_state_e                r_state;
   skid_state_e                w_stateNext;
   logic                       w_inFire;
   logic                       w_outFire;
   logic                       w_loadOutFromIn;
   logic                       w_loadOutFromSkid;
   logic                       w_loadSkid;

   tlul_rsp_intg_gen #(
      .EnableRspIntgGen  (EnableRspIntgGen),
      .EnableDataIntgGen (EnableDataIntgGen),
      .SzW               (SzW)
   ) u_intgGen (
      .d_opcode_i  (d_opcode_i),
      .d_size_i    (d_size_i),
      .d_error_i   (d_error_i),
      .d_data_i    (d_data_i),
      .rsp_intg_i  (rsp_intg_i),
      .data_intg_i (data_intg_i),
      .rsp_intg_o  (w_rspIntg),
      .data_intg_o (w_dataIntg)
   );

   assign w_inPayload = {d_opcode_i, d_param_i, d_size_i, d_source_i, d_sink_i,
                         d_data_i, d_error_i, w_rspIntg, w_dataIntg};

   // Both handshake outputs come straight from state bits, so d_ready_o never
   // depends combinationally on d_ready_i.
   assign d_valid_o = r_state[0];
   assign d_ready_o = ~r_state[1];
   assign w_inFire  = d_valid_i & d_ready_o;
   assign w_outFire = d_valid_o & d_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= StEmpty;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext       = r_state;
      w_loadOutFromIn   = 1'b0;
      w_loadOutFromSkid = 1'b0;
      w_loadSkid        = 1'b0;
      unique case (r_state)
         StEmpty: begin
            if (w_inFire) begin
               w_loadOutFromIn = 1'b1;
               w_stateNext     = StOne;
            end
         end
         StOne: begin
            if (w_inFire && w_outFire) begin
               w_loadOutFromIn = 1'b1;
            end else if (w_inFire) begin
               w_loadSkid  = 1'b1;
               w_stateNext = StFull;
            end else if (w_outFire) begin
               w_stateNext = StEmpty;
            end
         end
         StFull: begin
            if (w_outFire) begin
               w_loadOutFromSkid = 1'b1;
               w_stateNext       = StOne;
            end
         end
         default: begin
            w_stateNext = StEmpty;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_outPayload  <= '0;
         r_skidPayload <= '0;
      end else begin
         if (w_loadOutFromIn) begin
            r_outPayload <= w_inPayload;
         end else if (w_loadOutFromSkid) begin
            r_outPayload <= r_skidPayload;
         end
         if (w_loadSkid) begin
            r_skidPayload <= w_inPayload;
         end
      end
   end

   assign {d_opcode_o, d_param_o, d_size_o, d_source_o, d_sink_o,
           d_data_o, d_error_o, rsp_intg_o, data_intg_o} = r_outPayload;

endmodule

// File: tb/tb_tlul_rsp_intg_gen_skid.sv
// Self-checking bench for tlul_rsp_intg_gen_skid: a FIFO scoreboard plus
// scenario tasks for latency, back-to-back flow, skid/stall, pass-through and reset.
module tb_tlul_rsp_intg_gen_skid;

   localparam int SzW = 2;
   localparam int AiW = 8;

   typedef struct packed {
      logic [2:0]     opcode;
      logic [2:0]     param;
      logic [SzW-1:0] size;
      logic [AiW-1:0] source;
      logic           sink;
      logic [31:0]    data;
      logic           error;
      logic [6:0]     rspIntg;
      logic [6:0]     dataIntg;
   } rsp_t;

   localparam logic [63:0] RspMask [7] = '{
      64'h0103FFF800007FFF, 64'h017C1FF801FF801F, 64'h01BDE1F87E0781E1,
      64'h01DEEE3B8E388E22, 64'h01EF76CDB2C93244, 64'h01F7BB56D5525488,
      64'h01FBDDA769A46910};
   localparam logic [38:0] DataMask [7] = '{
      39'h002606BD25, 39'h00DEBA8050, 39'h00413D89AA, 39'h0031234ED1,
      39'h00C2C1323B, 39'h002DCC624C, 39'h0098505586};

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           d_valid_i = 1'b0;
   logic           d_ready_i = 1'b1;
   logic [2:0]     d_opcode_i = '0;
   logic [2:0]     d_param_i = '0;
   logic [SzW-1:0] d_size_i = '0;
   logic [AiW-1:0] d_source_i = '0;
   logic           d_sink_i = 1'b0;
   logic [31:0]    d_data_i = '0;
   logic           d_error_i = 1'b0;
   logic [6:0]     rsp_intg_i = '0;
   logic [6:0]     data_intg_i = '0;

   logic           d_ready_o, d_valid_o, d_sink_o, d_error_o;
   logic [2:0]     d_opcode_o, d_param_o;
   logic [SzW-1:0] d_size_o;
   logic [AiW-1:0] d_source_o;
   logic [31:0]    d_data_o;
   logic [6:0]     rsp_intg_o, data_intg_o;

   logic           pt_ready_o, pt_valid_o, pt_sink_o, pt_error_o;
   logic [2:0]     pt_opcode_o, pt_param_o;
   logic [SzW-1:0] pt_size_o;
   logic [AiW-1:0] pt_source_o;
   logic [31:0]    pt_data_o;
   logic [6:0]     pt_rsp_intg_o, pt_data_intg_o;

   int   checks = 0;
   int   fails  = 0;
   rsp_t expQ[$];

   always #5 clk = ~clk;

   tlul_rsp_intg_gen_skid #(
      .EnableRspIntgGen (1'b1), .EnableDataIntgGen (1'b1), .SzW (SzW), .AiW (AiW)
   ) dut (
      .clk_i (clk), .rst_i (rst), .d_valid_i (d_valid_i), .d_ready_o (d_ready_o),
      .d_opcode_i (d_opcode_i), .d_param_i (d_param_i), .d_size_i (d_size_i),
      .d_source_i (d_source_i), .d_sink_i (d_sink_i), .d_data_i (d_data_i),
      .d_error_i (d_error_i), .rsp_intg_i (rsp_intg_i), .data_intg_i (data_intg_i),
      .d_valid_o (d_valid_o), .d_ready_i (d_ready_i), .d_opcode_o (d_opcode_o),
      .d_param_o (d_param_o), .d_size_o (d_size_o), .d_source_o (d_source_o),
      .d_sink_o (d_sink_o), .d_data_o (d_data_o), .d_error_o (d_error_o),
      .rsp_intg_o (rsp_intg_o), .data_intg_o (data_intg_o)
   );

   tlul_rsp_intg_gen_skid #(
      .EnableRspIntgGen (1'b1), .EnableDataIntgGen (1'b0), .SzW (SzW), .AiW (AiW)
   ) dutPt (
      .clk_i (clk), .rst_i (rst), .d_valid_i (d_valid_i), .d_ready_o (pt_ready_o),
      .d_opcode_i (d_opcode_i), .d_param_i (d_param_i), .d_size_i (d_size_i),
      .d_source_i (d_source_i), .d_sink_i (d_sink_i), .d_data_i (d_data_i),
      .d_error_i (d_error_i), .rsp_intg_i (rsp_intg_i), .data_intg_i (data_intg_i),
      .d_valid_o (pt_valid_o), .d_ready_i (d_ready_i), .d_opcode_o (pt_opcode_o),
      .d_param_o (pt_param_o), .d_size_o (pt_size_o), .d_source_o (pt_source_o),
      .d_sink_o (pt_sink_o), .d_data_o (pt_data_o), .d_error_o (pt_error_o),
      .rsp_intg_o (pt_rsp_intg_o), .data_intg_o (pt_data_intg_o)
   );

   function automatic logic [6:0] refRspIntg(logic [2:0] op, logic [SzW-1:0] sz, logic err);
      logic [63:0] word;
      logic [6:0]  chk;
      word = 64'({op, sz, err});
      for (int i = 0; i < 7; i++) chk[i] = ($countones(word & RspMask[i]) % 2) == 1;
      return chk ^ 7'h2A;
   endfunction

   function automatic logic [6:0] refDataIntg(logic [31:0] data);
      logic [38:0] word;
      logic [6:0]  chk;
      word = 39'(data);
      for (int i = 0; i < 7; i++) chk[i] = ($countones(word & DataMask[i]) % 2) == 1;
      return chk ^ 7'h2A;
   endfunction

   function automatic rsp_t inputAsRsp();
      rsp_t r;
      r = {d_opcode_i, d_param_i, d_size_i, d_source_i, d_sink_i, d_data_i, d_error_i,
           refRspIntg(d_opcode_i, d_size_i, d_error_i), refDataIntg(d_data_i)};
      return r;
   endfunction

   function automatic rsp_t dutOut();
      rsp_t r;
      r = {d_opcode_o, d_param_o, d_size_o, d_source_o, d_sink_o, d_data_o, d_error_o,
           rsp_intg_o, data_intg_o};
      return r;
   endfunction

   // Reference model: an ordered queue of accepted responses, at most two deep.
   always @(negedge clk) begin
      if (rst) begin
         expQ.delete();
      end else begin
         checks++;
         if (d_valid_o !== (expQ.size() > 0)) begin
            fails++;
            $display("[TB] FAIL sb_valid: got %b expected %b", d_valid_o, expQ.size() > 0);
         end
         checks++;
         if (d_ready_o !== (expQ.size() < 2)) begin
            fails++;
            $display("[TB] FAIL sb_ready: got %b expected %b", d_ready_o, expQ.size() < 2);
         end
         if (d_valid_o && d_ready_i && expQ.size() > 0) begin
            checks++;
            if (dutOut() !== expQ[0]) begin
               fails++;
               $display("[TB] FAIL sb_payload: got %h expected %h", dutOut(), expQ[0]);
            end
            void'(expQ.pop_front());
         end
         if (d_valid_i && d_ready_o) expQ.push_back(inputAsRsp());
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyRandom(input int src);
      d_opcode_i  = 3'($urandom_range(0, 1));
      d_param_i   = 3'($urandom);
      d_size_i    = SzW'($urandom);
      d_source_i  = AiW'(src);
      d_sink_i    = 1'($urandom);
      d_data_i    = $urandom;
      d_error_i   = 1'($urandom);
      rsp_intg_i  = 7'($urandom);
      data_intg_i = 7'($urandom);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      d_valid_i = 1'b0;
      d_ready_i = 1'b1;
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (d_valid_o !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_valid: got %b expected 0", d_valid_o);
      end
      checks++;
      if (d_ready_o !== 1'b1) begin
         fails++;
         $display("[TB] FAIL reset_ready: got %b expected 1", d_ready_o);
      end
      checks++;
      if (dutOut() !== '0) begin
         fails++;
         $display("[TB] FAIL reset_payload: got %h expected 0", dutOut());
      end
      step();
   endtask

   task automatic test_first_response();
      {d_opcode_i, d_param_i, d_size_i, d_source_i, d_sink_i, d_data_i, d_error_i} = '0;
      d_ready_i = 1'b1;
      d_valid_i = 1'b1;
      step();
      d_valid_i = 1'b0;
      @(negedge clk);
      checks++;
      if (d_valid_o !== 1'b1) begin
         fails++;
         $display("[TB] FAIL first_latency: got valid %b expected 1", d_valid_o);
      end
      checks++;
      if (rsp_intg_o !== 7'h2A) begin
         fails++;
         $display("[TB] FAIL first_rsp_intg: got %h expected 2a", rsp_intg_o);
      end
      checks++;
      if (data_intg_o !== 7'h2A) begin
         fails++;
         $display("[TB] FAIL first_data_intg: got %h expected 2a", data_intg_o);
      end
      step();
   endtask

   task automatic test_back_to_back();
      d_ready_i = 1'b1;
      for (int i = 0; i <= 16; i++) begin
         if (i < 16) begin
            applyRandom(i);
            d_valid_i = 1'b1;
         end else begin
            d_valid_i = 1'b0;
         end
         @(negedge clk);
         checks++;
         if (d_ready_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL b2b_ready: cycle %0d got %b expected 1", i, d_ready_o);
         end
         if (i > 0) begin
            checks++;
            if (d_valid_o !== 1'b1 || d_source_o !== AiW'(i - 1)) begin
               fails++;
               $display("[TB] FAIL b2b_order: cycle %0d got valid %b src %0d expected valid 1 src %0d",
                        i, d_valid_o, d_source_o, i - 1);
            end
         end
         step();
      end
   endtask

   task automatic test_skid_and_stall();
      rsp_t snap;
      logic accepted;
      d_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyRandom(i);
         d_valid_i = 1'b1;
         @(negedge clk);
         if (i < 2) step();
      end
      checks++;
      if (d_ready_o !== 1'b0 || d_valid_o !== 1'b1 || d_source_o !== AiW'(0)) begin
         fails++;
         $display("[TB] FAIL skid_full: got ready %b valid %b src %0d expected 0 1 0",
                  d_ready_o, d_valid_o, d_source_o);
      end
      snap = dutOut();
      for (int c = 0; c < 10; c++) begin
         step();
         @(negedge clk);
         checks++;
         if (dutOut() !== snap || d_ready_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL stall_stable: cycle %0d got %h ready %b expected %h ready 0",
                     c, dutOut(), d_ready_o, snap);
         end
      end
      step();
      d_ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (d_valid_o !== 1'b1 || d_source_o !== AiW'(k)) begin
            fails++;
            $display("[TB] FAIL release_order: slot %0d got valid %b src %0d expected valid 1 src %0d",
                     k, d_valid_o, d_source_o, k);
         end
         accepted = d_valid_i && d_ready_o;
         step();
         if (accepted) d_valid_i = 1'b0;
      end
   endtask

   task automatic test_passthrough();
      logic [6:0] prevRsp;
      d_ready_i = 1'b1;
      applyRandom(8'h40);
      d_opcode_i  = 3'd1;
      d_size_i    = 2'd2;
      d_error_i   = 1'b0;
      data_intg_i = 7'h55;
      d_valid_i   = 1'b1;
      step();
      d_valid_i = 1'b0;
      @(negedge clk);
      checks++;
      if (pt_valid_o !== 1'b1 || pt_data_intg_o !== 7'h55) begin
         fails++;
         $display("[TB] FAIL pt_data_intg: got valid %b intg %h expected 1 55", pt_valid_o, pt_data_intg_o);
      end
      checks++;
      if (pt_rsp_intg_o !== refRspIntg(3'd1, 2'd2, 1'b0)) begin
         fails++;
         $display("[TB] FAIL pt_rsp_intg: got %h expected %h", pt_rsp_intg_o, refRspIntg(3'd1, 2'd2, 1'b0));
      end
      prevRsp = pt_rsp_intg_o;
      step();
      d_error_i = 1'b1;
      d_valid_i = 1'b1;
      step();
      d_valid_i = 1'b0;
      @(negedge clk);
      checks++;
      if (pt_rsp_intg_o === prevRsp) begin
         fails++;
         $display("[TB] FAIL pt_error_flip: got %h expected a value other than %h", pt_rsp_intg_o, prevRsp);
      end
      checks++;
      if (pt_rsp_intg_o !== refRspIntg(3'd1, 2'd2, 1'b1)) begin
         fails++;
         $display("[TB] FAIL pt_rsp_intg_err: got %h expected %h", pt_rsp_intg_o, refRspIntg(3'd1, 2'd2, 1'b1));
      end
      step();
   endtask

   task automatic test_reset_mid();
      d_ready_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         applyRandom(8'hA0 + i);
         d_valid_i = 1'b1;
         step();
      end
      d_valid_i = 1'b0;
      @(negedge clk);
      checks++;
      if (d_ready_o !== 1'b0) begin
         fails++;
         $display("[TB] FAIL midrst_full: got ready %b expected 0", d_ready_o);
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (d_valid_o !== 1'b0 || d_ready_o !== 1'b1) begin
         fails++;
         $display("[TB] FAIL midrst_after: got valid %b ready %b expected 0 1", d_valid_o, d_ready_o);
      end
      d_ready_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         @(negedge clk);
         checks++;
         if (d_valid_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midrst_discard: cycle %0d got valid %b expected 0", c, d_valid_o);
         end
      end
      step();
   endtask

   initial begin
      test_reset();
      test_first_response();
      test_back_to_back();
      test_skid_and_stall();
      test_passthrough();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
